div64x32_seq: RTL and testbench



---
 rtl/div_pkg.sv | 12 +
 rtl/div64x32_seq_if.sv | 30 +++
 rtl/div_step.sv | 23 ++
 rtl/div64x32_seq.sv | 133 +++++++++++++
 tb/tb_div64x32_seq.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential 64/32 divider.
package div_pkg;

    localparam int unsigned DIV_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div64x32_seq_if.sv
// Start/busy handshake and operand/result bus shared by the sequential arithmetic units.
interface div64x32_seq_if
    import div_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_W_DEFAULT
);

    logic                  start;
    logic [2*DATA_W-1:0]   a;
    logic [DATA_W-1:0]     b;
    logic                  busy;
    logic                  done;
    logic [DATA_W-1:0]     q;
    logic [DATA_W-1:0]     r;
    logic                  div_by_zero;
    logic                  overflow;

    // Host side: issues requests, observes results.
    modport master (
        output start, a, b,
        input  busy, done, q, r, div_by_zero, overflow
    );

    // Divider side.
    modport slave (
        input  start, a, b,
        output busy, done, q, r, div_by_zero, overflow
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
module div_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic              msb_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic              qbit
);

    logic [DATA_W:0] t;
    logic [DATA_W:0] d;

    // rem < divisor on entry, so the partial remainder after subtraction fits DATA_W bits.
    always_comb begin
        t        = {rem, msb_in};
        d        = {1'b0, divisor};
        qbit     = (t >= d);
        rem_next = qbit ? DATA_W'(t - d) : t[DATA_W-1:0];
    end

endmodule

// File: rtl/div64x32_seq.sv
// Iterative restoring divider: 2*DATA_W-bit dividend by DATA_W-bit divisor, one quotient bit per clock.
module div64x32_seq
    import div_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_W_DEFAULT,
    parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
    input  logic             clk,
    input  logic             reset,
    div64x32_seq_if.slave    bus
);

    div_state_t        state, state_next;

    // Partial remainder; the extra top bit of the textbook form is always zero since rem < b.
    logic [DATA_W-1:0] rem,  rem_d;
    logic [DATA_W-1:0] qsh,  qsh_d;
    logic [DATA_W-1:0] dvs,  dvs_d;
    logic [CNT_W-1:0]  cnt,  cnt_d;
    logic [DATA_W-1:0] q_reg, q_d;
    logic [DATA_W-1:0] r_reg, r_d;
    logic              dbz_reg, dbz_d;
    logic              ovf_reg, ovf_d;
    logic              busy_reg, done_reg;

    logic [DATA_W-1:0] step_rem;
    logic              step_qbit;
    logic [DATA_W-1:0] qsh_shift;

    // Single shift/subtract stage, reused every CALC cycle.
    div_step #(.DATA_W(DATA_W)) u_step (
        .rem      (rem),
        .msb_in   (qsh[DATA_W-1]),
        .divisor  (dvs),
        .rem_next (step_rem),
        .qbit     (step_qbit)
    );

    assign qsh_shift = {qsh[DATA_W-2:0], step_qbit};

    // Next-state and datapath update.
    always_comb begin
        state_next = state;
        rem_d      = rem;
        qsh_d      = qsh;
        dvs_d      = dvs;
        cnt_d      = cnt;
        q_d        = q_reg;
        r_d        = r_reg;
        dbz_d      = dbz_reg;
        ovf_d      = ovf_reg;

        unique case (state)
            IDLE, DONE: begin
                if (state == DONE) begin
                    state_next = IDLE;
                end
                if (bus.start) begin
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    if (bus.b == '0) begin
                        dbz_d      = 1'b1;
                        q_d        = '1;
                        r_d        = bus.a[DATA_W-1:0];
                        state_next = DONE;
                    end else if (bus.a[2*DATA_W-1:DATA_W] >= bus.b) begin
                        ovf_d      = 1'b1;
                        q_d        = '1;
                        r_d        = '0;
                        state_next = DONE;
                    end else begin
                        rem_d      = bus.a[2*DATA_W-1:DATA_W];
                        qsh_d      = bus.a[DATA_W-1:0];
                        dvs_d      = bus.b;
                        cnt_d      = CNT_W'(DATA_W - 1);
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                qsh_d = qsh_shift;
                if (cnt == '0) begin
                    q_d        = qsh_shift;
                    r_d        = step_rem;
                    state_next = DONE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rem      <= '0;
            qsh      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            q_reg    <= '0;
            r_reg    <= '0;
            dbz_reg  <= 1'b0;
            ovf_reg  <= 1'b0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            rem      <= rem_d;
            qsh      <= qsh_d;
            dvs      <= dvs_d;
            cnt      <= cnt_d;
            q_reg    <= q_d;
            r_reg    <= r_d;
            dbz_reg  <= dbz_d;
            ovf_reg  <= ovf_d;
            busy_reg <= (state_next == CALC);
            done_reg <= (state_next == DONE);
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.q           = q_reg;
    assign bus.r           = r_reg;
    assign bus.div_by_zero = dbz_reg;
    assign bus.overflow    = ovf_reg;

endmodule

// File: tb/tb_div64x32_seq.sv
// Directed and randomized checks for the sequential divider.
module tb_div64x32_seq;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    div64x32_seq_if #(.DATA_W(32)) bus ();

    div64x32_seq #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request; lat counts cycles from the accepting edge until done is seen.
    task automatic run_op(input logic [63:0] av, input logic [31:0] bv,
                          output int lat, output bit busy_seen);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        lat       = 0;
        busy_seen = 1'b0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            lat++;
            if (bus.busy) busy_seen = 1'b1;
        end while (!bus.done && lat < 100);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.overflow, bus.q, bus.r} !== 68'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b dbz=%b ovf=%b q=%h r=%h, required all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.overflow, bus.q, bus.r);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        bit bs;
        run_op(64'd100, 32'd7, lat, bs);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL basic_latency: got %0d, required 33", lat); end
        checks++;
        if (bus.q !== 32'd14 || bus.r !== 32'd2) begin
            errors++; $display("FAIL basic_result: q=%0d r=%0d, required q=14 r=2", bus.q, bus.r);
        end
        checks++;
        if (bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0 || bs !== 1'b1) begin
            errors++; $display("FAIL basic_flags: dbz=%b ovf=%b busy_seen=%b, required 0 0 1",
                               bus.div_by_zero, bus.overflow, bs);
        end
    endtask

    task automatic test_max();
        int  n;
        bit  partial;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 64'hFFFF_FFFE_0000_0001;
        bus.b     = 32'hFFFF_FFFF;
        n         = 0;
        partial   = 1'b0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            n++;
            if (bus.busy && (bus.q !== 32'd14 || bus.r !== 32'd2)) partial = 1'b1;
        end while (!bus.done && n < 100);
        checks++;
        if (partial !== 1'b0) begin errors++; $display("FAIL max_hold_during_calc: results changed while busy"); end
        checks++;
        if (bus.q !== 32'hFFFF_FFFF || bus.r !== 32'd0 || bus.overflow !== 1'b0 || n !== 33) begin
            errors++; $display("FAIL max_result: q=%h r=%h ovf=%b lat=%0d, required q=ffffffff r=0 ovf=0 lat=33",
                               bus.q, bus.r, bus.overflow, n);
        end
    endtask

    task automatic test_errors();
        int lat;
        bit bs;
        run_op(64'h0000_0005_0000_0000, 32'd5, lat, bs);
        checks++;
        if (lat !== 1 || bs !== 1'b0) begin
            errors++; $display("FAIL ovf_latency: lat=%0d busy_seen=%b, required 1 0", lat, bs);
        end
        checks++;
        if (bus.overflow !== 1'b1 || bus.div_by_zero !== 1'b0 || bus.q !== 32'hFFFF_FFFF || bus.r !== 32'd0) begin
            errors++; $display("FAIL ovf_result: ovf=%b dbz=%b q=%h r=%h, required 1 0 ffffffff 0",
                               bus.overflow, bus.div_by_zero, bus.q, bus.r);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: done=%b ovf=%b, required 0 1", bus.done, bus.overflow);
        end
        run_op(64'd10, 32'd0, lat, bs);
        checks++;
        if (lat !== 1 || bs !== 1'b0 || bus.div_by_zero !== 1'b1 || bus.overflow !== 1'b0 ||
            bus.q !== 32'hFFFF_FFFF || bus.r !== 32'd10) begin
            errors++; $display("FAIL dbz_result: lat=%0d busy_seen=%b dbz=%b ovf=%b q=%h r=%0d, required 1 0 1 0 ffffffff 10",
                               lat, bs, bus.div_by_zero, bus.overflow, bus.q, bus.r);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int m;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 64'd100;
        bus.b     = 32'd7;
        n         = 0;
        do begin
            @(negedge clk);
            n++;
            if (n >= 20) begin
                bus.start = 1'b1;
                bus.a     = 64'd1000;
                bus.b     = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
        end while (!bus.done && n < 100);
        checks++;
        if (n !== 33 || bus.q !== 32'd14 || bus.r !== 32'd2) begin
            errors++; $display("FAIL b2b_first: lat=%0d q=%0d r=%0d, required 33 14 2", n, bus.q, bus.r);
        end
        m = 0;
        do begin
            @(negedge clk);
            m++;
            if (m == 10) begin
                bus.start = 1'b1;
                bus.a     = 64'd77;
                bus.b     = 32'd0;
            end else begin
                bus.start = 1'b0;
            end
        end while (!bus.done && m < 100);
        checks++;
        if (m !== 33 || bus.q !== 32'd333 || bus.r !== 32'd1 || bus.div_by_zero !== 1'b0) begin
            errors++; $display("FAIL b2b_second: lat=%0d q=%0d r=%0d dbz=%b, required 33 333 1 0",
                               m, bus.q, bus.r, bus.div_by_zero);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: done=%b busy=%b, required 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        bit bs;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 64'd100;
        bus.b     = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.overflow, bus.q, bus.r} !== 68'd0) begin
            errors++; $display("FAIL reset_mid_calc: busy=%b done=%b q=%h r=%h, required all 0",
                               bus.busy, bus.done, bus.q, bus.r);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_stays_idle: busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
        run_op(64'd9, 32'd4, lat, bs);
        checks++;
        if (lat !== 33 || bus.q !== 32'd2 || bus.r !== 32'd1) begin
            errors++; $display("FAIL after_reset_op: lat=%0d q=%0d r=%0d, required 33 2 1", lat, bus.q, bus.r);
        end
    endtask

    task automatic test_random();
        int          lat;
        bit          bs;
        logic [31:0] bv;
        logic [63:0] av;
        logic [63:0] eq;
        logic [63:0] er;
        for (int i = 0; i < 1000; i++) begin
            bv = $urandom;
            if (i % 4 == 1) bv = bv & 32'h0000_00FF;
            if (bv == 32'd0) bv = 32'd1;
            av = {32'($urandom % bv), 32'($urandom)};
            eq = av / {32'd0, bv};
            er = av % {32'd0, bv};
            run_op(av, bv, lat, bs);
            checks++;
            if (lat !== 33 || bus.q !== eq[31:0] || bus.r !== er[31:0]) begin
                errors++; $display("FAIL random_%0d: a=%h b=%h q=%h r=%h lat=%0d, required q=%h r=%h lat=33",
                                   i, av, bv, bus.q, bus.r, lat, eq[31:0], er[31:0]);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0) begin
                errors++; $display("FAIL random_done_width_%0d: done=%b one cycle after pulse, required 0", i, bus.done);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_max();
        test_errors();
        test_back_to_back();
        test_reset_mid_calc();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
